mem_trace_logger: RTL and testbench
===================================

Name: mem_trace_logger

Overview:
- Taps the core's data-memory interface and records every committed store as a sequence of byte-granular entries (byte address, byte value).
- Presents the log as flat arrays to the contract checker, which scans the entries per retired instruction to resolve memory-operand observations.
- Two instances run in the dual-core verification top, one per core. Each instance is the writer side of the checker's memory-trace inputs.

Parameters:
- DEPTH, 32, number of byte entries in the log.
- AW, 32, address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous log flush
- data_req_i  in  1  LSU request
- data_gnt_i  in  1  memory grant
- data_we_i  in  1  request is a store
- data_be_i  in  4  byte enables
- data_addr_i  in  AW  word address (bits 1:0 ignored)
- data_wdata_i  in  32  store data, lane-aligned
- data_rvalid_i  in  1  response valid
- data_err_i  in  1  response error
- mem_addr_o  out  DEPTH*AW  entry k at bits [k*AW +: AW]
- mem_data_o  out  DEPTH*8  entry k byte at bits [k*8 +: 8]
- valid_o  out  DEPTH  per-entry valid
- count_o  out  $clog2(DEPTH+1)  valid entry count, saturates at DEPTH
- busy_o  out  1  FSM not IDLE or pending slot occupied
- drop_o  out  1  sticky: a granted store was lost

Behaviour:
- Reset (async, rst_i=1):
  - all mem_addr_o, mem_data_o, valid_o, count_o, busy_o, drop_o = 0.
  - FSM in IDLE; pending slot empty.
- Log ordering is a shift register, with the newest entry at index DEPTH-1.
  - Each insert shifts entry[k] <= entry[k+1] for k < DEPTH-1 and writes the new entry at DEPTH-1.
  - Entry 0 is discarded on shift.
  - The highest-index match is therefore always the newest byte.
  - Invalid entries hold addr=0, data=0; consumers qualify with valid_o.
- Capture: a store is granted on a cycle with data_req_i & data_gnt_i & data_we_i. The capture latches {addr[AW-1:2], be, wdata}.
  - Loads (we=0) are never captured.
  - Their rvalid is ignored unless a store is outstanding. The LSU guarantees in-order responses with one outstanding transaction.
- FSM states:
  - IDLE:
    - store grant -> latch into active, go to WAIT.
  - WAIT:
    - rvalid & err -> discard active. If pending is full, move it to active and go to WAIT; else go to IDLE.
    - rvalid & !err & be!=0 -> DRAIN, with remaining mask = be.
    - rvalid & !err & be==0 -> same as the err case (no entries).
  - DRAIN:
    - One entry per cycle for the lowest set bit j of the remaining mask: addr={addr[AW-1:2],2'b00}+j, data=wdata[8j+:8]. Bit j is then cleared.
    - When the mask becomes zero in this cycle, take pending if present (-> WAIT), else -> IDLE.
    - Drain latency is popcount(be) cycles, starting the cycle after rvalid.
- Pending slot (1 deep): a store grant arriving while in WAIT or DRAIN is latched into pending.
  - If pending is already full, the new grant is dropped and drop_o is set (sticky until clear/reset).
  - A grant arriving in the same cycle that pending is consumed is accepted.
- Address arithmetic is modulo 2^AW; the +j never carries because bits 1:0 are zero.
- count_o increments on each insert and saturates at DEPTH. valid_o shifts together with the entries, and a 1 is inserted at DEPTH-1.
- clear_i (synchronous) restores every state and output to its reset value.
  - clear_i has priority over a same-cycle grant, rvalid or drain insert; those events are lost without setting drop_o.
- All outputs are registered. They change only on the posedge and are stable at the negedge, where the checker samples them.

Test Plan:
- SW of 0xDEADBEEF to 0x1000, be=4'hF, rvalid 1 cycle after grant -> 4 inserts on cycles 2..5. Entries 28..31 = (0x1000,EF),(0x1001,BE),(0x1002,AD),(0x1003,DE); count_o=4; busy_o low after cycle 5.
- SB with be=4'b0100, wdata=0x00AA0000, addr 0x2002 -> single entry (0x2002,0xAA) at index 31; a load with rvalid in the same sequence adds nothing.
- Store with data_err_i=1 on rvalid -> no entries, count_o unchanged, FSM back to IDLE next cycle.
- Three back-to-back store grants while the first is still in WAIT -> second held in pending, third dropped, drop_o=1. Log contains only the bytes of the first two stores, in order.
- Ten SW stores (40 bytes) -> count_o=32, oldest 8 bytes gone, entry 31 = last byte of the 10th store, all valid_o bits set.
- clear_i asserted mid-DRAIN (after 2 of 4 bytes) -> next cycle all outputs 0, FSM IDLE. A following rvalid is ignored. rst_i pulsed asynchronously mid-WAIT -> outputs 0 immediately.

Source files
------------

// File: rtl/mem_trace_logger.sv
// mem_trace_logger: logs committed LSU stores as byte entries (addr, data), newest at DEPTH-1
// Ports: clk_i/rst_i (async, active-high) clock and reset; clear_i synchronous flush;
//        data_* LSU request/grant/response tap; mem_addr_o/mem_data_o/valid_o flat log,
//        entry k at [k*AW +: AW] / [k*8 +: 8] / [k]; count_o saturating entry count;
//        busy_o capture in progress; drop_o sticky lost-store flag.
module mem_trace_logger #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         data_req_i,
    input  logic                         data_gnt_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [AW-1:0]                data_addr_i,
    input  logic [31:0]                  data_wdata_i,
    input  logic                         data_rvalid_i,
    input  logic                         data_err_i,
    output logic [DEPTH*AW-1:0]          mem_addr_o,
    output logic [DEPTH*8-1:0]           mem_data_o,
    output logic [DEPTH-1:0]             valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         busy_o,
    output logic                         drop_o
);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] act_addr_q, act_addr_d, pend_addr_q, pend_addr_d;
    logic [3:0]    act_be_q, act_be_d, pend_be_q, pend_be_d, rem_q, rem_d;
    logic [31:0]   act_wdata_q, act_wdata_d, pend_wdata_q, pend_wdata_d;
    logic          pend_v_q, pend_v_d, take_pend, ins, drop_d, grant;
    logic [1:0]    j;
    logic [AW-1:0] new_addr;
    logic [7:0]    new_data;

    always_comb begin
        grant        = data_req_i & data_gnt_i & data_we_i;
        j            = rem_q[0] ? 2'd0 : rem_q[1] ? 2'd1 : rem_q[2] ? 2'd2 : 2'd3;
        // Word-align the latched address, then select the byte lane; never carries.
        new_addr     = (act_addr_q & ~AW'(3)) | AW'(j);
        new_data     = act_wdata_q[{j, 3'b000} +: 8];
        state_d      = state_q;
        act_addr_d   = act_addr_q;
        act_be_d     = act_be_q;
        act_wdata_d  = act_wdata_q;
        rem_d        = rem_q;
        take_pend    = 1'b0;
        ins          = 1'b0;
        case (state_q)
            IDLE: if (grant) begin
                state_d     = WAIT;
                act_addr_d  = data_addr_i;
                act_be_d    = data_be_i;
                act_wdata_d = data_wdata_i;
            end
            WAIT: if (data_rvalid_i) begin
                if (data_err_i || act_be_q == 4'd0) begin
                    take_pend = pend_v_q;
                    state_d   = pend_v_q ? WAIT : IDLE;
                end else begin
                    state_d = DRAIN;
                    rem_d   = act_be_q;
                end
            end
            DRAIN: begin
                ins   = 1'b1;
                rem_d = rem_q & (rem_q - 4'd1);
                if (rem_d == 4'd0) begin
                    take_pend = pend_v_q;
                    state_d   = pend_v_q ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take_pend) begin
            act_addr_d  = pend_addr_q;
            act_be_d    = pend_be_q;
            act_wdata_d = pend_wdata_q;
        end
        // Pending slot frees in the same cycle it is consumed, so a coincident grant fits.
        pend_v_d     = pend_v_q & ~take_pend;
        pend_addr_d  = pend_addr_q;
        pend_be_d    = pend_be_q;
        pend_wdata_d = pend_wdata_q;
        drop_d       = drop_o;
        if (grant && state_q != IDLE) begin
            if (!pend_v_d) begin
                pend_v_d     = 1'b1;
                pend_addr_d  = data_addr_i;
                pend_be_d    = data_be_i;
                pend_wdata_d = data_wdata_i;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else if (clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_addr_q   <= '0;
            act_be_q     <= '0;
            act_wdata_q  <= '0;
            pend_addr_q  <= '0;
            pend_be_q    <= '0;
            pend_wdata_q <= '0;
            pend_v_q     <= 1'b0;
            rem_q        <= '0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            valid_o      <= '0;
            count_o      <= '0;
            busy_o       <= 1'b0;
            drop_o       <= 1'b0;
        end else if (clear_i) begin
            act_addr_q   <= '0;
            act_be_q     <= '0;
            act_wdata_q  <= '0;
            pend_addr_q  <= '0;
            pend_be_q    <= '0;
            pend_wdata_q <= '0;
            pend_v_q     <= 1'b0;
            rem_q        <= '0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            valid_o      <= '0;
            count_o      <= '0;
            busy_o       <= 1'b0;
            drop_o       <= 1'b0;
        end else begin
            act_addr_q   <= act_addr_d;
            act_be_q     <= act_be_d;
            act_wdata_q  <= act_wdata_d;
            pend_addr_q  <= pend_addr_d;
            pend_be_q    <= pend_be_d;
            pend_wdata_q <= pend_wdata_d;
            pend_v_q     <= pend_v_d;
            rem_q        <= rem_d;
            busy_o       <= (state_d != IDLE) || pend_v_d;
            drop_o       <= drop_d;
            if (ins) begin
                mem_addr_o <= {new_addr, mem_addr_o[DEPTH*AW-1:AW]};
                mem_data_o <= {new_data, mem_data_o[DEPTH*8-1:8]};
                valid_o    <= {1'b1, valid_o[DEPTH-1:1]};
                count_o    <= (count_o == CW'(DEPTH)) ? count_o : count_o + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_trace_logger.sv
// tb_mem_trace_logger: directed self-checking bench for mem_trace_logger
`timescale 1ns/1ps
module tb_mem_trace_logger;
    logic          clk_i = 1'b0, rst_i = 1'b1, clear_i = 1'b0;
    logic          data_req_i = 1'b0, data_gnt_i = 1'b0, data_we_i = 1'b0;
    logic [3:0]    data_be_i = '0;
    logic [31:0]   data_addr_i = '0, data_wdata_i = '0;
    logic          data_rvalid_i = 1'b0, data_err_i = 1'b0;
    logic [1023:0] mem_addr_o;
    logic [255:0]  mem_data_o;
    logic [31:0]   valid_o;
    logic [5:0]    count_o;
    logic          busy_o, drop_o;
    int            checks = 0, errors = 0;

    mem_trace_logger #(.DEPTH(32), .AW(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .data_req_i(data_req_i), .data_gnt_i(data_gnt_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .valid_o(valid_o),
        .count_o(count_o), .busy_o(busy_o), .drop_o(drop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        data_req_i = 1'b1; data_gnt_i = 1'b1; data_we_i = we;
        data_addr_i = a; data_be_i = be; data_wdata_i = d;
        tick(1);
        data_req_i = 1'b0; data_gnt_i = 1'b0; data_we_i = 1'b0;
    endtask

    task automatic rv(input logic err);
        data_rvalid_i = 1'b1; data_err_i = err;
        tick(1);
        data_rvalid_i = 1'b0; data_err_i = 1'b0;
    endtask

    task automatic clr();
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
    endtask

    task automatic chk_entry(input string tag, input int k, input logic [31:0] a, input logic [7:0] d);
        chk({tag, "_addr"}, 64'(mem_addr_o[k*32 +: 32]), 64'(a));
        chk({tag, "_data"}, 64'(mem_data_o[k*8 +: 8]), 64'(d));
    endtask

    initial begin
        #12;
        chk("rst_cnt", 64'(count_o), 0);
        chk("rst_valid", 64'(valid_o), 0);
        chk("rst_busy_drop", 64'({busy_o, drop_o}), 0);
        chk("rst_log_zero", 64'(mem_addr_o == '0 && mem_data_o == '0), 1);
        rst_i = 1'b0;

        req(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF);
        rv(1'b0);
        tick(3);
        @(negedge clk_i);
        chk("sw_cnt3", 64'(count_o), 3);
        chk("sw_busy_mid", 64'(busy_o), 1);
        tick(1);
        @(negedge clk_i);
        chk("sw_cnt4", 64'(count_o), 4);
        chk("sw_busy_end", 64'(busy_o), 0);
        chk("sw_valid", 64'(valid_o), 64'hF000_0000);
        chk_entry("sw_e28", 28, 32'h1000, 8'hEF);
        chk_entry("sw_e29", 29, 32'h1001, 8'hBE);
        chk_entry("sw_e30", 30, 32'h1002, 8'hAD);
        chk_entry("sw_e31", 31, 32'h1003, 8'hDE);

        clr();
        req(1'b1, 32'h2002, 4'b0100, 32'h00AA0000);
        rv(1'b0);
        tick(1);
        req(1'b0, 32'h2100, 4'hF, 32'h0);
        rv(1'b0);
        tick(2);
        @(negedge clk_i);
        chk("sb_cnt", 64'(count_o), 1);
        chk("sb_valid", 64'(valid_o), 64'h8000_0000);
        chk_entry("sb_e31", 31, 32'h2002, 8'hAA);
        chk_entry("sb_e30", 30, 32'h0, 8'h00);

        req(1'b1, 32'h3000, 4'hF, 32'h01020304);
        rv(1'b1);
        @(negedge clk_i);
        chk("err_busy", 64'(busy_o), 0);
        chk("err_cnt", 64'(count_o), 1);
        tick(2);
        chk("err_cnt_late", 64'(count_o), 1);
        chk_entry("err_e31", 31, 32'h2002, 8'hAA);

        clr();
        req(1'b1, 32'h4000, 4'hF, 32'h11223344);
        req(1'b1, 32'h5000, 4'b0011, 32'h0000BBAA);
        req(1'b1, 32'h6000, 4'hF, 32'h55667788);
        @(negedge clk_i);
        chk("pend_drop", 64'(drop_o), 1);
        chk("pend_busy", 64'(busy_o), 1);
        rv(1'b0);
        tick(4);
        rv(1'b0);
        tick(2);
        @(negedge clk_i);
        chk("pend_cnt", 64'(count_o), 6);
        chk("pend_busy_end", 64'(busy_o), 0);
        chk("pend_drop_sticky", 64'(drop_o), 1);
        chk_entry("pend_e26", 26, 32'h4000, 8'h44);
        chk_entry("pend_e29", 29, 32'h4003, 8'h11);
        chk_entry("pend_e30", 30, 32'h5000, 8'hAA);
        chk_entry("pend_e31", 31, 32'h5001, 8'hBB);
        chk("pend_valid", 64'(valid_o), 64'hFC00_0000);

        clr();
        chk("clr_drop", 64'(drop_o), 0);
        for (int i = 0; i < 10; i++) begin
            req(1'b1, 32'h6000 + 32'(4*i), 4'hF,
                {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
            rv(1'b0);
            tick(4);
        end
        @(negedge clk_i);
        chk("sat_cnt", 64'(count_o), 32);
        chk("sat_valid", 64'(valid_o), 64'hFFFF_FFFF);
        chk_entry("sat_e0", 0, 32'h6008, 8'h08);
        chk_entry("sat_e31", 31, 32'h6027, 8'h27);

        clr();
        req(1'b1, 32'h7000, 4'hF, 32'hCAFEF00D);
        rv(1'b0);
        tick(2);
        @(negedge clk_i);
        chk("mid_cnt2", 64'(count_o), 2);
        clr();
        @(negedge clk_i);
        chk("clr_cnt", 64'(count_o), 0);
        chk("clr_busy", 64'(busy_o), 0);
        chk("clr_valid", 64'(valid_o), 0);
        chk("clr_log_zero", 64'(mem_addr_o == '0 && mem_data_o == '0), 1);
        rv(1'b0);
        tick(2);
        chk("clr_rv_cnt", 64'(count_o), 0);
        chk("clr_rv_busy", 64'(busy_o), 0);

        req(1'b1, 32'h8000, 4'b0001, 32'h000000C3);
        rv(1'b0);
        tick(1);
        req(1'b1, 32'h9000, 4'hF, 32'h12345678);
        chk("arst_pre_cnt", 64'(count_o), 1);
        chk("arst_pre_busy", 64'(busy_o), 1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_cnt", 64'(count_o), 0);
        chk("arst_busy", 64'(busy_o), 0);
        chk("arst_valid", 64'(valid_o), 0);
        chk("arst_log_zero", 64'(mem_addr_o == '0 && mem_data_o == '0), 1);
        #2 rst_i = 1'b0;
        rv(1'b0);
        tick(2);
        chk("arst_rv_cnt", 64'(count_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
